// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: widths, ALU opcodes, CCR bit positions,
// jump-select codes and operand-B source codes.
package ex_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SHMT_W = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CCR_W  = 4;
  localparam int unsigned IMM_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_NOT = 4'd4;
  localparam logic [OP_W-1:0] OP_INC = 4'd5;
  localparam logic [OP_W-1:0] OP_DEC = 4'd6;
  localparam logic [OP_W-1:0] OP_SHL = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR = 4'd8;
  localparam logic [OP_W-1:0] OP_MOV = 4'd9;
  localparam logic [OP_W-1:0] OP_CMP = 4'd10;
  localparam logic [OP_W-1:0] OP_NOP = 4'd11;

  localparam int unsigned CCR_Z   = 0;
  localparam int unsigned CCR_N   = 1;
  localparam int unsigned CCR_C   = 2;
  localparam int unsigned CCR_INT = 3;

  localparam logic [1:0] JMP_Z      = 2'd0;
  localparam logic [1:0] JMP_N      = 2'd1;
  localparam logic [1:0] JMP_C      = 2'd2;
  localparam logic [1:0] JMP_ALWAYS = 2'd3;

  localparam logic [1:0] SRC_RSRC = 2'd0;
  localparam logic [1:0] SRC_DATA = 2'd1;
  localparam logic [1:0] SRC_IMM  = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU: result plus candidate Z/N/C values and which of them the op updates.
module ex_alu
  import ex_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SHMT_W-1:0] shmt,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n,
  output logic              c,
  output logic              c_valid,
  output logic              zn_valid
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   shl_ext;
  logic [DATA_W:0]   shr_ext;
  logic [DATA_W-1:0] flag_src;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    // MSB of the widened difference is the unsigned borrow (a < b)
    diff     = {1'b0, a} - {1'b0, b};
    shl_ext  = {1'b0, a} << shmt;
    shr_ext  = {a, 1'b0} >> shmt;
    result   = a;
    c        = 1'b0;
    c_valid  = 1'b0;
    zn_valid = 1'b1;
    case (op)
      OP_ADD: begin result = sum[DATA_W-1:0];  c = sum[DATA_W];  c_valid = 1'b1; end
      OP_SUB: begin result = diff[DATA_W-1:0]; c = diff[DATA_W]; c_valid = 1'b1; end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOT: result = ~a;
      OP_INC: begin result = a + DATA_W'(1); c = &a;  c_valid = 1'b1; end
      OP_DEC: begin result = a - DATA_W'(1); c = ~|a; c_valid = 1'b1; end
      // Bit shifted out last lands in the guard bit of the widened value
      OP_SHL: begin result = shl_ext[DATA_W-1:0]; c = shl_ext[DATA_W]; c_valid = |shmt; end
      OP_SHR: begin result = shr_ext[DATA_W:1];   c = shr_ext[0];      c_valid = |shmt; end
      OP_MOV: begin result = b; zn_valid = 1'b0; end
      OP_CMP: begin result = a; c = diff[DATA_W]; c_valid = 1'b1; end
      default: zn_valid = 1'b0;
    endcase
    flag_src = (op == OP_CMP) ? diff[DATA_W-1:0] : result;
    z        = ~|flag_src;
    n        = flag_src[DATA_W-1];
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand-B select, ALU, jump decision and the CCR {INT,C,N,Z} register.
module ex_stage
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [OP_W-1:0]   ALU_OP,
  input  logic [1:0]        ALU_src1,
  input  logic [DATA_W-1:0] Rdst_val,
  input  logic [DATA_W-1:0] Rsrc_val,
  input  logic [DATA_W-1:0] Data,
  input  logic [IMM_W-1:0]  hash_imm,
  input  logic [SHMT_W-1:0] Shmt,
  input  logic              set_Z,
  input  logic              set_N,
  input  logic              set_C,
  input  logic              set_INT,
  input  logic              clr_Z,
  input  logic              clr_N,
  input  logic              clr_C,
  input  logic              clr_INT,
  input  logic              is_jmp,
  input  logic [1:0]        jmp_sel,
  input  logic              flags_pop_vld,
  input  logic [CCR_W-1:0]  flags_pop_data,
  output logic [DATA_W-1:0] alu_result,
  output logic [CCR_W-1:0]  flags_out,
  output logic              take_jmp,
  output logic [DATA_W-1:0] jmp_target
);

  logic [CCR_W-1:0]  ccr;
  logic [CCR_W-1:0]  ccr_next;
  logic [CCR_W-1:0]  set_vec;
  logic [CCR_W-1:0]  clr_vec;
  logic [CCR_W-1:0]  jmp_clr;
  logic [CCR_W-1:0]  alu_mask;
  logic [CCR_W-1:0]  alu_val;
  logic [DATA_W-1:0] opnd_b;
  logic              alu_z;
  logic              alu_n;
  logic              alu_c;
  logic              alu_c_valid;
  logic              alu_zn_valid;

  always_comb begin
    case (ALU_src1)
      SRC_RSRC: opnd_b = Rsrc_val;
      SRC_DATA: opnd_b = Data;
      SRC_IMM:  opnd_b = DATA_W'(hash_imm);
      default:  opnd_b = '0;
    endcase
  end

  ex_alu u_alu (
    .op       (ALU_OP),
    .a        (Rdst_val),
    .b        (opnd_b),
    .shmt     (Shmt),
    .result   (alu_result),
    .z        (alu_z),
    .n        (alu_n),
    .c        (alu_c),
    .c_valid  (alu_c_valid),
    .zn_valid (alu_zn_valid)
  );

  assign jmp_target = Rdst_val;

  // Jump decision uses the registered CCR; a taken conditional jump consumes its flag
  always_comb begin
    take_jmp = is_jmp & ((jmp_sel == JMP_ALWAYS) | ccr[jmp_sel]);
    jmp_clr  = '0;
    if (take_jmp && (jmp_sel != JMP_ALWAYS)) jmp_clr[jmp_sel] = 1'b1;
  end

  always_comb begin
    set_vec  = {set_INT, set_C, set_N, set_Z};
    clr_vec  = {clr_INT, clr_C, clr_N, clr_Z};
    alu_mask = {1'b0, alu_c_valid, alu_zn_valid, alu_zn_valid};
    alu_val  = {1'b0, alu_c, alu_n, alu_z};
    ccr_next = ccr;
    // Popped flags come from MEM, which keeps running while EX is stalled
    if (flags_pop_vld) begin
      ccr_next = flags_pop_data;
    end else if (!stall) begin
      ccr_next = ((((ccr & ~alu_mask) | (alu_val & alu_mask)) & ~jmp_clr) | set_vec) & ~clr_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ccr <= '0;
    else       ccr <= ccr_next;
  end

  assign flags_out = ccr;

endmodule
